// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: FETCH/DECODE/EXEC/MEM/WB control sequencer with ready handshakes, wait timeout and sticky halt/error
module multicycle_ctrl_fsm #(
  parameter int OPW = 4,
  parameter int ALUOPW = 2,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OPW-1:0]    opcode,
  input  logic              mem_ready,
  input  logic              flag_z,
  output logic              if_req,
  output logic              ir_load,
  output logic              pc_inc,
  output logic              pc_load,
  output logic [ALUOPW-1:0] ALUop,
  output logic              ALUsrc,
  output logic              regwdst,
  output logic              mem2reg,
  output logic              imm,
  output logic              memr,
  output logic              memw,
  output logic              regw_en,
  output logic              upd_flag,
  output logic              hlt,
  output logic              err,
  output logic [2:0]        state
);
  localparam int CW = WAIT_MAX > 0 ? $clog2(WAIT_MAX + 1) : 1;
  typedef enum logic [2:0] {
    IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3,
    MEM = 3'd4, WB = 3'd5, HALT = 3'd6, ERR = 3'd7
  } state_t;
  state_t state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] op;
  logic act, wait_st, timeout, illegal;
  // DECODE sees the instruction register directly; later states use the latched copy
  assign op = state_q == DECODE ? opcode[3:0] : op_q[3:0];
  assign act = state_q inside {DECODE, EXEC, MEM, WB};
  assign wait_st = state_q inside {FETCH, MEM};
  assign timeout = WAIT_MAX > 0 && !mem_ready && cnt_q == CW'(WAIT_MAX - 1);
  assign illegal = (opcode >> 4) != '0 || opcode[3:0] inside {4'b1010, 4'b1011, 4'b1110};
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    cnt_d = wait_st && !mem_ready ? cnt_q + 1'b1 : '0;
    case (state_q)
      IDLE:   state_d = FETCH;
      FETCH:  state_d = mem_ready ? DECODE : timeout ? ERR : FETCH;
      DECODE: begin
        op_d = opcode;
        state_d = illegal ? ERR : opcode[3:0] == 4'b1111 ? HALT : opcode[3:0] == 4'b1001 ? FETCH : EXEC;
      end
      EXEC:   state_d = op inside {4'b1100, 4'b1101} ? FETCH : op inside {4'b0101, 4'b0110} ? MEM : WB;
      MEM:    state_d = mem_ready ? (op == 4'b0101 ? WB : FETCH) : timeout ? ERR : MEM;
      WB:     state_d = FETCH;
      default: state_d = state_q;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      cnt_q <= cnt_d;
    end
  end
  assign state = state_q;
  assign if_req = state_q == FETCH;
  assign ir_load = if_req && mem_ready;
  assign pc_inc = if_req && mem_ready;
  assign pc_load = (state_q == DECODE && op == 4'b1001) || (state_q == EXEC && op == 4'b1101 && flag_z);
  assign upd_flag = state_q == EXEC && op == 4'b1100;
  assign memr = state_q == MEM && op == 4'b0101;
  assign memw = state_q == MEM && op == 4'b0110;
  assign regw_en = state_q == WB;
  assign hlt = state_q == HALT;
  assign err = state_q == ERR;
  assign regwdst = act && op <= 4'b0100;
  assign ALUsrc = act && op inside {4'b0101, 4'b0110};
  assign mem2reg = act && op == 4'b0101;
  assign imm = act && op == 4'b1000;
  assign ALUop = !act ? '0 : op inside {4'b0101, 4'b0110, 4'b1101} ? ALUOPW'(2) : op == 4'b1100 ? ALUOPW'(1) : '0;
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: directed checks of sequencing, handshakes, timeout, halt/error and async reset
module tb_multicycle_ctrl_fsm;
  logic clk = 0, rst = 1, mem_ready = 0, flag_z = 0;
  logic [3:0] opcode = '0;
  logic if_req, ir_load, pc_inc, pc_load, ALUsrc, regwdst, mem2reg, imm;
  logic memr, memw, regw_en, upd_flag, hlt, err;
  logic [1:0] ALUop;
  logic [2:0] state;
  logic [15:0] outs;
  int n_chk = 0, n_fail = 0;
  multicycle_ctrl_fsm #(.OPW(4), .ALUOPW(2), .WAIT_MAX(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .flag_z(flag_z),
    .if_req(if_req), .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .ALUop(ALUop),
    .ALUsrc(ALUsrc), .regwdst(regwdst), .mem2reg(mem2reg), .imm(imm), .memr(memr), .memw(memw),
    .regw_en(regw_en), .upd_flag(upd_flag), .hlt(hlt), .err(err), .state(state)
  );
  assign outs = {if_req, ir_load, pc_inc, pc_load, ALUop, ALUsrc, regwdst, mem2reg, imm,
                 memr, memw, regw_en, upd_flag, hlt, err};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic [3:0] op, input logic fz);
    @(negedge clk);
    mem_ready = r;
    opcode = op;
    flag_z = fz;
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
  endtask
  initial begin
    mem_ready = 1;
    #3;
    chk("rst_state", state, 0);
    chk("rst_outs", outs, 0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("idle_state", state, 0);
    chk("idle_outs", outs, 0);
    // ADD: FETCH, DECODE, EXEC, WB
    cyc(1, 4'h0, 0); chk("add_fetch", state, 1); chk("add_irld", ir_load, 1); chk("add_pcinc", pc_inc, 1);
    cyc(1, 4'h0, 0); chk("add_dec", state, 2); chk("add_dec_rd", regwdst, 1); chk("add_dec_rw", regw_en, 0);
    cyc(1, 4'h0, 0); chk("add_exe", state, 3); chk("add_exe_rd", regwdst, 1); chk("add_exe_rw", regw_en, 0);
    cyc(1, 4'h0, 0); chk("add_wb", state, 5); chk("add_wb_rw", regw_en, 1); chk("add_wb_rd", regwdst, 1);
    cyc(1, 4'h5, 0); chk("ld_fetch", state, 1); chk("ld_fetch_rw", regw_en, 0);
    // LOAD with two wait cycles in MEM
    cyc(1, 4'h5, 0); chk("ld_dec", state, 2);
    cyc(1, 4'h5, 0); chk("ld_exe", state, 3); chk("ld_exe_aluop", ALUop, 2);
    cyc(0, 4'h5, 0); chk("ld_mem0", state, 4); chk("ld_mem0_r", memr, 1); chk("ld_m2r", mem2reg, 1);
    chk("ld_alusrc", ALUsrc, 1); chk("ld_aluop", ALUop, 2); chk("ld_memw", memw, 0);
    cyc(0, 4'h5, 0); chk("ld_mem1", state, 4); chk("ld_mem1_r", memr, 1);
    cyc(1, 4'h5, 0); chk("ld_mem2", state, 4); chk("ld_mem2_r", memr, 1);
    cyc(1, 4'hd, 1); chk("ld_wb", state, 5); chk("ld_wb_r", memr, 0); chk("ld_wb_rw", regw_en, 1);
    // B taken, B not taken, JUMP, CMP
    cyc(1, 4'hd, 1); chk("bt_fetch", state, 1);
    cyc(1, 4'hd, 1); chk("bt_dec", state, 2); chk("bt_dec_pcl", pc_load, 0);
    cyc(1, 4'hd, 1); chk("bt_exe", state, 3); chk("bt_pcl", pc_load, 1); chk("bt_aluop", ALUop, 2);
    cyc(1, 4'hd, 0); chk("bn_fetch", state, 1); chk("bt_pcl_off", pc_load, 0);
    cyc(1, 4'hd, 0); chk("bn_dec", state, 2);
    cyc(1, 4'h9, 0); chk("bn_exe", state, 3); chk("bn_pcl", pc_load, 0);
    cyc(1, 4'h9, 0); chk("jmp_fetch", state, 1);
    cyc(1, 4'h9, 0); chk("jmp_dec", state, 2); chk("jmp_pcl", pc_load, 1);
    cyc(1, 4'hc, 0); chk("cmp_fetch", state, 1); chk("jmp_pcl_off", pc_load, 0);
    cyc(1, 4'hc, 0); chk("cmp_dec", state, 2);
    cyc(1, 4'h6, 0); chk("cmp_exe", state, 3); chk("cmp_upd", upd_flag, 1); chk("cmp_aluop", ALUop, 1);
    // STORE interrupted by reset in MEM
    cyc(1, 4'h6, 0); chk("st_fetch", state, 1); chk("cmp_upd_off", upd_flag, 0);
    cyc(1, 4'h6, 0); chk("st_dec", state, 2);
    cyc(0, 4'h6, 0); chk("st_exe", state, 3);
    cyc(0, 4'h6, 0); chk("st_mem", state, 4); chk("st_memw", memw, 1); chk("st_memr", memr, 0);
    rst = 1;
    #1;
    chk("st_rst_memw", memw, 0); chk("st_rst_state", state, 0); chk("st_rst_rw", regw_en, 0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("st_rst_idle", state, 0);
    // Timeout after four not-ready FETCH cycles
    cyc(0, 4'h0, 0); chk("to_f0", state, 1);
    cyc(0, 4'h0, 0); chk("to_f1", state, 1);
    cyc(0, 4'h0, 0); chk("to_f2", state, 1);
    cyc(0, 4'h0, 0); chk("to_f3", state, 1);
    cyc(0, 4'h0, 0); chk("to_err", state, 7); chk("to_err_flag", err, 1);
    cyc(1, 4'h0, 0); chk("to_err_sticky", state, 7); chk("to_err_flag2", err, 1);
    // Ready on the fourth cycle wins over timeout, then HALT
    do_reset();
    cyc(0, 4'hf, 0); chk("rd_f0", state, 1);
    cyc(0, 4'hf, 0); chk("rd_f1", state, 1);
    cyc(0, 4'hf, 0); chk("rd_f2", state, 1);
    cyc(1, 4'hf, 0); chk("rd_f3", state, 1); chk("rd_irld", ir_load, 1);
    cyc(1, 4'hf, 0); chk("rd_dec", state, 2);
    for (int i = 0; i < 20; i++) begin
      cyc(1'($urandom_range(0, 1)), 4'h0, 0);
      chk("halt_state", state, 6);
      chk("halt_outs", outs, 16'h0002);
    end
    // Illegal opcode
    do_reset();
    cyc(1, 4'ha, 0); chk("ill_fetch", state, 1);
    cyc(1, 4'ha, 0); chk("ill_dec", state, 2);
    cyc(1, 4'h0, 0); chk("ill_err", state, 7); chk("ill_outs", outs, 16'h0001);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
